multicore_cmd_mem_loader: RTL
=============================

Name: multicore_cmd_mem_loader

Overview:
Command memory subsystem for multi-core simulation toplevels and later hardware builds. Holds one command memory per processor core. Each memory is built from MEM_TO_CMD banks, each MEM_WIDTH bits wide. Each core gets an independent read port with fixed read latency. A single streaming loader fills any core's memory from a narrow MEM_WIDTH word stream. The loader assembles full commands, then writes all banks of the selected core at once.

Parameters:
N_CORES, 2, number of cores (each core has its own memory and read port)
CMD_ADDR_WIDTH, 8, command address width; depth per core is 2**CMD_ADDR_WIDTH
MEM_WIDTH, 32, bank word width and loader stream width
MEM_TO_CMD, 4, banks per command; command width = MEM_WIDTH*MEM_TO_CMD
READ_LATENCY, 3, cycles from instr_ptr to cmd_out; legal values >=1
CORE_SEL_WIDTH, 2, width of ld_core; must satisfy 2**CORE_SEL_WIDTH >= N_CORES

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ld_start  in  1  single-cycle load request
ld_core  in  CORE_SEL_WIDTH  target core, sampled on accepted ld_start
ld_base_addr  in  CMD_ADDR_WIDTH  first command address, sampled on start
ld_len  in  CMD_ADDR_WIDTH+1  number of commands to load, sampled on start
ld_data  in  MEM_WIDTH  stream word, low bank first
ld_valid  in  1  ld_data valid
ld_ready  out  1  loader accepts a word
ld_busy  out  1  transfer in progress
ld_done  out  1  one-cycle pulse when a transfer completes
ld_err  out  1  sticky error for an out-of-range ld_core
instr_ptr  in  N_CORES*CMD_ADDR_WIDTH  per-core read addresses, core i at slice i
cmd_out  out  N_CORES*MEM_WIDTH*MEM_TO_CMD  per-core commands, core i at slice i, bank j at bits [MEM_WIDTH*(j+1)-1:MEM_WIDTH*j] within the slice

Behaviour:
- Reset
  - All outputs go to 0 and the FSM goes to IDLE.
  - Word and command counters and the assembly registers are cleared.
  - The read pipeline registers are cleared, so cmd_out is 0 until READ_LATENCY cycles after reset deasserts.
  - Memory contents are NOT cleared.
- Reset mid-transfer: the transfer is abandoned. A partially assembled command is discarded. Commands already written stay in memory. ld_done is not pulsed.
- Read path
  - Per core, per bank: synchronous read, then a (READ_LATENCY-1)-stage output register pipeline.
  - cmd_out at cycle t+READ_LATENCY reflects instr_ptr at cycle t.
  - Cores are fully independent.
- Read/write same address in the same cycle: the read returns the old data (read-first). The new data is visible to a read issued on the next cycle.
- IDLE state
  - ld_ready=0, ld_busy=0.
  - On ld_start: latch core, address and length; clear ld_err.
    - ld_len==0: go to DONE (no writes).
    - Otherwise: go to LOAD.
    - ld_core>=N_CORES: set ld_err, go to LOAD in discard mode. Words are consumed; no memory is written.
- LOAD state
  - ld_ready=1, ld_busy=1. A handshake is ld_valid&&ld_ready.
  - Word k of a command goes to bank k. word_cnt counts 0..MEM_TO_CMD-1 and wraps.
  - The handshake of word MEM_TO_CMD-1 writes all banks of the target core at cur_addr on that same clock edge. The write uses the stored words 0..MEM_TO_CMD-2 plus the current ld_data.
  - After each full command: cur_addr increments modulo 2**CMD_ADDR_WIDTH (wraps silently) and the remaining count decrements.
  - When the remaining count reaches 0: go to DONE.
  - ld_valid gaps are allowed; no timeout.
- DONE state
  - ld_ready=0, ld_busy=1, ld_done=1 for exactly one cycle, then IDLE.
  - The final write has completed before ld_done rises.
- ld_start is ignored while ld_busy=1.
  - In IDLE it is accepted on the same cycle it is asserted, so back-to-back transfers are possible: a start in the cycle after DONE is accepted.
- Words presented with ld_valid while ld_ready=0 are not consumed.
- ld_err stays high until the next accepted ld_start or reset.

Test Plan:
- Basic load: start core 0, base 0x10, len 2, feed 8 words 0x00..0x07 with ld_valid held high.
  - ld_done pulses 9 cycles after the start cycle (1 cycle IDLE→LOAD, 8 words, then DONE).
  - instr_ptr[core0]=0x10 gives cmd_out = {0x03,0x02,0x01,0x00} 3 cycles later.
  - Address 0x11 gives {0x07,0x06,0x05,0x04}.
- Core isolation and latency: load core 1 addr 0x10 with 0xAAAA_0000-based words.
  - Core 0 addr 0x10 data is unchanged.
  - Changing both instr_ptr slices on the same cycle gives both outputs exactly READ_LATENCY cycles later.
- Wrap and gaps: base 0xFF, len 2, ld_valid toggling every other cycle.
  - Commands land at 0xFF and 0x00.
  - ld_ready stays high throughout LOAD; ld_done pulses once.
- Boundaries:
  - len 0: ld_done pulses on the cycle after start, memory is unchanged, ld_ready never rises.
  - ld_core=3 with N_CORES=2: ld_err=1, 4*len words consumed, no memory changed, ld_done pulses.
  - A later valid start clears ld_err.
- Collision: a write to core 0 addr 0x20 in the same cycle instr_ptr=0x20.
  - cmd_out shows the old value after 3 cycles.
  - The next-cycle read shows the new value.
- Reset mid-transfer: reset after 6 of 8 words.
  - The first command is present and the second address is unchanged.
  - ld_done is never pulsed; cmd_out=0 for 3 cycles after reset.
  - A new load succeeds.

Source files
------------

// File: rtl/multicore_cmd_mem_loader.sv
// Per-core command memories (MEM_TO_CMD banks each) with independent fixed-latency
// read ports, filled by a single streaming loader that assembles full commands.
module multicore_cmd_mem_loader #(
  parameter int N_CORES        = 2,
  parameter int CMD_ADDR_WIDTH = 8,
  parameter int MEM_WIDTH      = 32,
  parameter int MEM_TO_CMD     = 4,
  parameter int READ_LATENCY   = 3,
  parameter int CORE_SEL_WIDTH = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      ld_start,
  input  logic [CORE_SEL_WIDTH-1:0]                 ld_core,
  input  logic [CMD_ADDR_WIDTH-1:0]                 ld_base_addr,
  input  logic [CMD_ADDR_WIDTH:0]                   ld_len,
  input  logic [MEM_WIDTH-1:0]                      ld_data,
  input  logic                                      ld_valid,
  output logic                                      ld_ready,
  output logic                                      ld_busy,
  output logic                                      ld_done,
  output logic                                      ld_err,
  input  logic [N_CORES*CMD_ADDR_WIDTH-1:0]         instr_ptr,
  output logic [N_CORES*MEM_WIDTH*MEM_TO_CMD-1:0]   cmd_out
);

  localparam int DEPTH = 2 ** CMD_ADDR_WIDTH;
  localparam int WCW   = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;
  localparam logic [WCW-1:0]            LAST_WORD = WCW'(MEM_TO_CMD - 1);
  localparam logic [CORE_SEL_WIDTH:0]   N_CORES_W = (CORE_SEL_WIDTH + 1)'(N_CORES);
  localparam logic [CMD_ADDR_WIDTH:0]   ONE_LEFT  = (CMD_ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                    state;
  logic [CORE_SEL_WIDTH-1:0] cur_core;
  logic [CMD_ADDR_WIDTH-1:0] cur_addr;
  logic [CMD_ADDR_WIDTH:0]   remaining;
  logic [WCW-1:0]            word_cnt;
  logic                      discard;
  logic [MEM_WIDTH-1:0]      asm_word [MEM_TO_CMD];
  logic                      hs;
  logic                      cmd_we;
  logic                      core_bad;

  assign hs       = ld_ready && ld_valid;
  // The final word is written straight from ld_data, so the command lands on its own handshake edge.
  assign cmd_we   = hs && !reset && !discard && (word_cnt == LAST_WORD);
  assign core_bad = {1'b0, ld_core} >= N_CORES_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_core  <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      word_cnt  <= '0;
      discard   <= 1'b0;
      ld_ready  <= 1'b0;
      ld_busy   <= 1'b0;
      ld_done   <= 1'b0;
      ld_err    <= 1'b0;
      for (int unsigned i = 0; i < MEM_TO_CMD; i++) asm_word[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            cur_core  <= ld_core;
            cur_addr  <= ld_base_addr;
            remaining <= ld_len;
            word_cnt  <= '0;
            discard   <= core_bad;
            ld_err    <= core_bad;
            ld_busy   <= 1'b1;
            if (ld_len == '0) begin
              state   <= DONE;
              ld_done <= 1'b1;
            end else begin
              state    <= LOAD;
              ld_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            asm_word[word_cnt] <= ld_data;
            if (word_cnt == LAST_WORD) begin
              word_cnt  <= '0;
              cur_addr  <= cur_addr + 1'b1;
              remaining <= remaining - 1'b1;
              if (remaining == ONE_LEFT) begin
                state    <= DONE;
                ld_ready <= 1'b0;
                ld_done  <= 1'b1;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          ld_busy <= 1'b0;
          ld_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    logic [CMD_ADDR_WIDTH-1:0] rd_addr;
    logic                      core_we;

    assign rd_addr = instr_ptr[c*CMD_ADDR_WIDTH +: CMD_ADDR_WIDTH];
    assign core_we = cmd_we && (cur_core == CORE_SEL_WIDTH'(c));

    for (genvar b = 0; b < MEM_TO_CMD; b++) begin : g_bank
      logic [MEM_WIDTH-1:0] mem  [DEPTH];
      logic [MEM_WIDTH-1:0] pipe [READ_LATENCY];
      logic [MEM_WIDTH-1:0] wr_word;

      assign wr_word = (b == MEM_TO_CMD - 1) ? ld_data : asm_word[b];

      always_ff @(posedge clk) begin
        if (core_we) mem[cur_addr] <= wr_word;
      end

      // Read-first: pipe[0] samples the array before the same-edge write lands.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mem[rd_addr];
          for (int unsigned i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign cmd_out[(c*MEM_TO_CMD + b)*MEM_WIDTH +: MEM_WIDTH] = pipe[READ_LATENCY-1];
    end
  end

endmodule
